// File: rtl/sysarray_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sysarray_ctrl_pkg
// Shared definitions for the systolic-array sequencing controller.
//   FP_W      : width of one floating-point operand lane
//   state_t   : controller FSM states
//   drain_len : number of cycles the wavefront needs to leave an N x N array
// -----------------------------------------------------------------------------
package sysarray_ctrl_pkg;

    localparam int FP_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

    // The last operand pair reaches PE(N-1,N-1) 2N cycles after the final
    // read is issued (one buffer cycle, N-1 skew, N-1 systolic hops, plus the
    // first skew stage), so the controller waits that long after feeding.
    function automatic int drain_len(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/sysarray_ctrl_skew_line.sv
// -----------------------------------------------------------------------------
// skew_line
// DEPTH-stage register chain carrying one operand lane plus its valid bit.
// The output is forced to zero whenever the last stage is not valid, so the
// array only ever sees real operands or zeros.
//   clk  : clock
//   rst  : asynchronous active-high reset, empties the chain
//   din  : operand from the buffer
//   vin  : din carries a real operand this cycle
//   dout : delayed operand, zero when invalid
// -----------------------------------------------------------------------------
module skew_line
    import sysarray_ctrl_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [FP_W-1:0] din,
    input  logic            vin,
    output logic [FP_W-1:0] dout
);

    logic [FP_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;

    // Shift register for data and valid. Invalid input is stored as zero so
    // buffer garbage never propagates down the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                data_q[s] <= '0;
            end
            vld_q <= '0;
        end else begin
            data_q[0] <= vin ? din : '0;
            vld_q[0]  <= vin;
            for (int s = 1; s < DEPTH; s++) begin
                data_q[s] <= data_q[s-1];
                vld_q[s]  <= vld_q[s-1];
            end
        end
    end

    assign dout = vld_q[DEPTH-1] ? data_q[DEPTH-1] : '0;

endmodule

// File: rtl/sysarray_ctrl.sv
// -----------------------------------------------------------------------------
// sysarray_ctrl
// Sequencer for an N x N output-stationary systolic array. On start it clears
// the array, reads K operand columns/rows from the buffers, skews them onto
// the array edges, waits for the wavefront to drain and pulses done.
//   clk, rst : clock, asynchronous active-high reset
//   start    : run request, honoured only in IDLE
//   k_len    : inner dimension, clamped to K_MAX
//   busy     : high outside IDLE
//   done     : one-cycle pulse, array results final
//   rd_en    : operand buffer read strobe
//   rd_k     : operand index of the current read
//   a_col    : A[i][k] lanes, valid the cycle after rd_en
//   b_row    : B[k][j] lanes, valid the cycle after rd_en
//   left_o   : skewed left-edge feed, row i delayed i+1 cycles
//   up_o     : skewed top-edge feed, column j delayed j+1 cycles
//   arr_rst  : registered accumulator clear for every array PE
// -----------------------------------------------------------------------------
module sysarray_ctrl
    import sysarray_ctrl_pkg::*;
#(
    parameter int N     = 4,
    parameter int K_MAX = 16,
    parameter int KW    = $clog2(K_MAX + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [KW-1:0]   rd_k,
    input  logic [N*32-1:0] a_col,
    input  logic [N*32-1:0] b_row,
    output logic [N*32-1:0] left_o,
    output logic [N*32-1:0] up_o,
    output logic            arr_rst
);

    localparam int DRAIN_LEN = drain_len(N);
    localparam int DW        = $clog2(DRAIN_LEN + 1);
    localparam logic [KW-1:0] K_MAX_V    = KW'(K_MAX);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_LEN - 1);

    state_t        state_q;
    state_t        state_d;
    logic [KW-1:0] k_reg;
    logic [KW-1:0] k_cnt;
    logic [DW-1:0] drain_cnt;
    logic          rd_en_q;
    logic          arr_rst_q;

    // Next-state logic. FEED lasts exactly K cycles and DRAIN exactly 2N;
    // a zero-length job skips straight from CLEAR to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   state_d = (k_reg == '0) ? DONE : FEED;
            FEED:    if (k_cnt == KW'(k_reg - KW'(1))) state_d = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the clamped inner dimension when a job is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_reg <= '0;
        end else if (state_q == IDLE && start) begin
            k_reg <= (k_len > K_MAX_V) ? K_MAX_V : k_len;
        end
    end

    // Read index counter. It only advances while staying in FEED so that
    // rd_k is back at zero the moment FEED ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_cnt <= '0;
        end else if (state_q == FEED && state_d == FEED) begin
            k_cnt <= k_cnt + KW'(1);
        end else begin
            k_cnt <= '0;
        end
    end

    // Drain counter, running only while the wavefront leaves the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt <= '0;
        end else if (state_q == DRAIN) begin
            drain_cnt <= drain_cnt + DW'(1);
        end else begin
            drain_cnt <= '0;
        end
    end

    // Buffer data arrives one cycle after the read strobe, so the strobe is
    // delayed once to become the valid bit entering every skew lane. The
    // array clear is a flop so the PEs see a glitch-free asynchronous reset;
    // it holds during reset and is high exactly for the CLEAR cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en_q   <= 1'b0;
            arr_rst_q <= 1'b1;
        end else begin
            rd_en_q   <= (state_q == FEED);
            arr_rst_q <= (state_d == CLEAR);
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign rd_en   = (state_q == FEED);
    assign rd_k    = k_cnt;
    assign arr_rst = arr_rst_q;

    // One skew line per row (left edge) and per column (top edge); lane i
    // is i+1 stages deep to produce the diagonal wavefront.
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_line #(.DEPTH(i + 1)) u_row (
            .clk  (clk),
            .rst  (rst),
            .din  (a_col[32*i +: 32]),
            .vin  (rd_en_q),
            .dout (left_o[32*i +: 32])
        );
        skew_line #(.DEPTH(i + 1)) u_col (
            .clk  (clk),
            .rst  (rst),
            .din  (b_row[32*i +: 32]),
            .vin  (rd_en_q),
            .dout (up_o[32*i +: 32])
        );
    end

endmodule

// File: tb/tb_sysarray_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sysarray_ctrl
// Self-checking bench for sysarray_ctrl with N=4, K_MAX=16. An operand buffer
// model answers reads, a scoreboard predicts every skewed edge value, and a
// behavioural output-stationary array accumulates what the DUT feeds it so
// the final dot products can be compared with a golden matrix product.
// -----------------------------------------------------------------------------
module tb_sysarray_ctrl;

    localparam int N     = 4;
    localparam int K_MAX = 16;
    localparam int KW    = $clog2(K_MAX + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [KW-1:0]   k_len;
    logic            busy;
    logic            done;
    logic            rd_en;
    logic [KW-1:0]   rd_k;
    logic [N*32-1:0] a_col;
    logic [N*32-1:0] b_row;
    logic [N*32-1:0] left_o;
    logic [N*32-1:0] up_o;
    logic            arr_rst;

    sysarray_ctrl #(.N(N), .K_MAX(K_MAX), .KW(KW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .k_len   (k_len),
        .busy    (busy),
        .done    (done),
        .rd_en   (rd_en),
        .rd_k    (rd_k),
        .a_col   (a_col),
        .b_row   (b_row),
        .left_o  (left_o),
        .up_o    (up_o),
        .arr_rst (arr_rst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [KW-1:0] k_len;
        int            pattern;
        int            exp_reads;
        int            exp_lat;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          pattern = 0;
    int          read_cnt = 0;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          rd_seq[$];
    exp_t        qa[N][$];
    exp_t        qb[N][$];
    logic        pend_v = 1'b0;
    logic [KW-1:0] pend_k = '0;
    real         acc[N][N];
    real         snap[N][N];
    logic [31:0] a_reg[N][N];
    logic [31:0] b_reg[N][N];
    vec_t        vecs[5];

    // Compare helpers: every check goes through one of these.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutputReal(input string name, input real act, input real exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %f expected %f", name, act, exp);
        end
    endtask

    // IEEE single bits to real, enough for the small exact values used here.
    function automatic real f2r(input logic [31:0] x);
        real r;
        int  e;
        if (x[30:0] == 31'd0) return 0.0;
        e = int'(x[30:23]) - 127;
        r = 1.0 + real'(x[22:0]) / 8388608.0;
        if (e > 0) begin
            for (int t = 0; t < e; t++) r = r * 2.0;
        end else begin
            for (int t = 0; t < -e; t++) r = r / 2.0;
        end
        return x[31] ? -r : r;
    endfunction

    // Small non-negative integer to IEEE single bits.
    function automatic logic [31:0] i2f(input int v);
        int e;
        int m;
        if (v <= 0) return 32'h0;
        e = 0;
        while ((v >> (e + 1)) != 0) e++;
        m = (v << (23 - e)) & 32'h007F_FFFF;
        return {1'b0, 8'(127 + e), 23'(m)};
    endfunction

    // Operand patterns: 0 = small worked example, 1 = identity x 2.0, 2 = ints.
    function automatic logic [31:0] a_val(input int p, input int i, input int k);
        case (p)
            0: return (k != 0) ? 32'h0 : (i == 0) ? 32'h3F80_0000 : (i == 1) ? 32'h4000_0000 : 32'h0;
            1: return (i == k) ? 32'h3F80_0000 : 32'h0;
            default: return i2f(i + 1);
        endcase
    endfunction

    function automatic logic [31:0] b_val(input int p, input int k, input int j);
        case (p)
            0: return (k != 0) ? 32'h0 : (j == 0) ? 32'h4040_0000 : (j == 1) ? 32'h4080_0000 : 32'h0;
            1: return 32'h4000_0000;
            default: return i2f((k + j) % 5);
        endcase
    endfunction

    // Operand buffer: answers a read one cycle later, garbage otherwise.
    initial begin
        a_col = '0;
        b_row = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                a_col[32*i +: 32] = pend_v ? a_val(pattern, i, int'(pend_k)) : $urandom;
                b_row[32*i +: 32] = pend_v ? b_val(pattern, int'(pend_k), i) : $urandom;
            end
            pend_v = 1'b0;
        end
    end

    // Per-cycle monitor: edge-lane scoreboard, array model, event counters.
    initial begin
        logic [31:0] ev;
        logic [31:0] ai;
        logic [31:0] bi;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                for (int i = 0; i < N; i++) begin
                    qa[i].delete();
                    qb[i].delete();
                end
                pend_v = 1'b0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    ev = 32'h0;
                    if (qa[i].size() > 0 && qa[i][0].cyc == cyc) begin
                        ev = qa[i][0].data;
                        void'(qa[i].pop_front());
                    end
                    checkOutput($sformatf("left%0d@%0d", i, cyc), 64'(left_o[32*i +: 32]), 64'(ev));
                    ev = 32'h0;
                    if (qb[i].size() > 0 && qb[i][0].cyc == cyc) begin
                        ev = qb[i][0].data;
                        void'(qb[i].pop_front());
                    end
                    checkOutput($sformatf("up%0d@%0d", i, cyc), 64'(up_o[32*i +: 32]), 64'(ev));
                end
                if (busy) busy_cnt++;
                if (rd_en) begin
                    read_cnt++;
                    rd_seq.push_back(int'(rd_k));
                    pend_v = 1'b1;
                    pend_k = rd_k;
                    for (int i = 0; i < N; i++) begin
                        qa[i].push_back('{cyc: cyc + 2 + i, data: a_val(pattern, i, int'(rd_k))});
                        qb[i].push_back('{cyc: cyc + 2 + i, data: b_val(pattern, int'(rd_k), i)});
                    end
                end
            end
            if (arr_rst) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        acc[i][j]   = 0.0;
                        a_reg[i][j] = 32'h0;
                        b_reg[i][j] = 32'h0;
                    end
                end
            end else begin
                for (int i = N - 1; i >= 0; i--) begin
                    for (int j = N - 1; j >= 0; j--) begin
                        ai = (j == 0) ? left_o[32*i +: 32] : a_reg[i][j-1];
                        bi = (i == 0) ? up_o[32*j +: 32] : b_reg[i-1][j];
                        acc[i][j]   = acc[i][j] + f2r(ai) * f2r(bi);
                        a_reg[i][j] = ai;
                        b_reg[i][j] = bi;
                    end
                end
            end
            if (done && !rst) begin
                done_cnt++;
                done_cyc = cyc;
                snap = acc;
            end
        end
    end

    // Wait, with a cycle budget, until the monitor has seen n done pulses.
    task automatic waitDone(input int n, input string name);
        int t;
        t = 0;
        while (done_cnt < n && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (done_cnt < n) checkOutput({name, "_done_timeout"}, 64'(done_cnt), 64'(n));
    endtask

    // Golden matrix product against the array snapshot taken at done.
    task automatic checkResults(input int keff, input int p, input string name);
        real g;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                g = 0.0;
                for (int k = 0; k < keff; k++) g = g + f2r(a_val(p, i, k)) * f2r(b_val(p, k, j));
                checkOutputReal($sformatf("%s_res%0d%0d", name, i, j), snap[i][j], g);
            end
        end
    endtask

    task automatic checkSeq(input int n, input string name);
        checkOutput({name, "_rdseq_len"}, 64'(rd_seq.size()), 64'(n));
        for (int q = 0; q < rd_seq.size(); q++) begin
            checkOutput($sformatf("%s_rdk%0d", name, q), 64'(rd_seq[q]), 64'(q));
        end
    endtask

    task automatic clearCounts();
        read_cnt = 0;
        busy_cnt = 0;
        done_cnt = 0;
        rd_seq.delete();
    endtask

    // Run one table vector from IDLE and check timing, reads and results.
    task automatic applyStimulus(input vec_t v, input string name);
        int s_cyc;
        pattern = v.pattern;
        clearCounts();
        k_len = v.k_len;
        start = 1'b1;
        s_cyc = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(1, name);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput({name, "_latency"}, 64'(done_cyc - s_cyc), 64'(v.exp_lat));
        checkOutput({name, "_reads"}, 64'(read_cnt), 64'(v.exp_reads));
        checkOutput({name, "_busy"}, 64'(busy_cnt), 64'(v.exp_lat));
        checkOutput({name, "_done_pulses"}, 64'(done_cnt), 64'(1));
        checkSeq(v.exp_reads, name);
        checkResults(v.exp_reads, v.pattern, name);
    endtask

    initial begin
        int s_cyc;
        int d1;
        int t;
        vec_t v;

        // k_len, pattern, expected reads, expected start-to-done latency (K+2N+2)
        vecs[0] = '{k_len: KW'(1),  pattern: 0, exp_reads: 1,  exp_lat: 11};
        vecs[1] = '{k_len: KW'(4),  pattern: 1, exp_reads: 4,  exp_lat: 14};
        vecs[2] = '{k_len: KW'(0),  pattern: 2, exp_reads: 0,  exp_lat: 2};
        vecs[3] = '{k_len: KW'(3),  pattern: 2, exp_reads: 3,  exp_lat: 13};
        vecs[4] = '{k_len: KW'(19), pattern: 2, exp_reads: 16, exp_lat: 26};

        rst   = 1'b1;
        start = 1'b0;
        k_len = '0;
        #3;
        checkOutput("rst_busy",    64'(busy),    64'(0));
        checkOutput("rst_done",    64'(done),    64'(0));
        checkOutput("rst_rd_en",   64'(rd_en),   64'(0));
        checkOutput("rst_rd_k",    64'(rd_k),    64'(0));
        checkOutput("rst_left",    64'(left_o),  64'(0));
        checkOutput("rst_up",      64'(up_o),    64'(0));
        checkOutput("rst_arr_rst", 64'(arr_rst), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("arr_rst_release", 64'(arr_rst), 64'(0));

        for (int n = 0; n < 5; n++) begin
            $display("[TB] vector %0d k_len=%0d pattern=%0d", n, vecs[n].k_len, vecs[n].pattern);
            applyStimulus(vecs[n], $sformatf("vec%0d", n));
        end

        // A second start during a run must be ignored entirely.
        $display("[TB] start while busy");
        pattern = 2;
        clearCounts();
        k_len = KW'(4);
        start = 1'b1;
        s_cyc = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        k_len = KW'(7);
        start = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        waitDone(1, "ign");
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("ign_latency", 64'(done_cyc - s_cyc), 64'(14));
        checkOutput("ign_done_pulses", 64'(done_cnt), 64'(1));
        checkSeq(4, "ign");
        checkResults(4, 2, "ign");

        // Start held high: accepted again in the IDLE cycle right after DONE.
        $display("[TB] back-to-back");
        pattern = 1;
        clearCounts();
        k_len = KW'(4);
        start = 1'b1;
        s_cyc = cyc + 1;
        waitDone(1, "b2b1");
        d1 = done_cyc;
        checkOutput("b2b1_latency", 64'(d1 - s_cyc), 64'(14));
        checkResults(4, 1, "b2b1");
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(2, "b2b2");
        checkOutput("b2b2_gap", 64'(done_cyc - d1), 64'(15));
        checkOutput("b2b2_reads", 64'(read_cnt), 64'(8));
        checkResults(4, 1, "b2b2");
        repeat (3) begin
            @(posedge clk);
            #1;
        end

        // Reset in the middle of FEED, then a clean run.
        $display("[TB] reset mid-feed");
        pattern = 2;
        clearCounts();
        k_len = KW'(4);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t = 0;
        while (!(rd_en && rd_k == KW'(2)) && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        checkOutput("midrst_reached_k2", 64'(rd_en && rd_k == KW'(2)), 64'(1));
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy",    64'(busy),    64'(0));
        checkOutput("midrst_done",    64'(done),    64'(0));
        checkOutput("midrst_rd_en",   64'(rd_en),   64'(0));
        checkOutput("midrst_rd_k",    64'(rd_k),    64'(0));
        checkOutput("midrst_left",    64'(left_o),  64'(0));
        checkOutput("midrst_up",      64'(up_o),    64'(0));
        checkOutput("midrst_arr_rst", 64'(arr_rst), 64'(1));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        v = vecs[3];
        applyStimulus(v, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
